// File: rtl/instruction_compressor.sv
// RV32I -> RVC compressor: shrinks eligible instructions to 16-bit parcels
// and packs the parcel stream into 32-bit fetch words.
module instruction_compressor (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] cnt_compressed
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rd    = in_instr[11:7];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign imm_i = in_instr[31:20];
  assign imm_s = {in_instr[31:25], in_instr[11:7]};

  logic is_addi;
  logic is_add;
  logic imm6;
  logic c_li;
  logic c_addi;
  logic c_mv;
  logic c_add;
  logic c_jr;
  logic c_lw;
  logic c_sw;

  assign is_addi = (opc == 7'h13) && (f3 == 3'b000);
  assign is_add  = (opc == 7'h33) && (f3 == 3'b000) && (f7 == 7'h00)
                && (rd != 5'd0) && (rs2 != 5'd0);
  assign imm6    = (imm_i[11:5] == {7{imm_i[5]}});

  assign c_li   = is_addi && (rs1 == 5'd0) && (rd != 5'd0) && imm6;
  assign c_addi = is_addi && (rs1 == rd) && (rd != 5'd0)
               && (imm_i != 12'd0) && imm6;
  assign c_mv   = is_add && (rs1 == 5'd0);
  assign c_add  = is_add && (rs1 == rd);
  assign c_jr   = (opc == 7'h67) && (f3 == 3'b000) && (rd == 5'd0)
               && (imm_i == 12'd0) && (rs1 != 5'd0);
  // Compressed loads/stores reach only x8..x15 and word offsets 0..124.
  assign c_lw   = (opc == 7'h03) && (f3 == 3'b010)
               && (rd[4:3] == 2'b01) && (rs1[4:3] == 2'b01)
               && (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
  assign c_sw   = (opc == 7'h23) && (f3 == 3'b010)
               && (rs2[4:3] == 2'b01) && (rs1[4:3] == 2'b01)
               && (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);

  logic        is_c;
  logic [15:0] parcel;

  always_comb begin
    is_c   = 1'b1;
    parcel = 16'h0000;
    unique case (1'b1)
      c_li:   parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      c_addi: parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      c_mv:   parcel = {4'b1000, rd, rs2, 2'b10};
      c_add:  parcel = {4'b1001, rd, rs2, 2'b10};
      c_jr:   parcel = {4'b1000, rs1, 5'd0, 2'b10};
      c_lw:   parcel = {3'b010, imm_i[5:3], rs1[2:0],
                        imm_i[2], imm_i[6], rd[2:0], 2'b00};
      c_sw:   parcel = {3'b110, imm_s[5:3], rs1[2:0],
                        imm_s[2], imm_s[6], rs2[2:0], 2'b00};
      default: is_c = 1'b0;
    endcase
  end

  state_e      state_q;
  state_e      state_d;
  logic [15:0] pend_q;
  logic [15:0] pend_d;
  logic [31:0] word_q;
  logic [31:0] word_d;
  logic        valid_q;
  logic        valid_d;
  logic        flush_q;
  logic        flush_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        accept;

  assign in_ready       = !valid_q || out_ready;
  assign accept         = in_valid && in_ready;
  assign out_word       = word_q;
  assign out_valid      = valid_q;
  assign cnt_compressed = cnt_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    word_d  = word_q;
    valid_d = valid_q && !out_ready;
    flush_d = flush_q || flush;
    cnt_d   = cnt_q;
    if (accept) begin
      if (is_c) cnt_d = cnt_q + 16'd1;
      unique case (state_q)
        EMPTY: begin
          if (is_c) begin
            pend_d  = parcel;
            state_d = HALF;
          end else begin
            word_d  = in_instr;
            valid_d = 1'b1;
          end
        end
        HALF: begin
          valid_d = 1'b1;
          if (is_c) begin
            word_d  = {parcel, pend_q};
            state_d = EMPTY;
          end else begin
            word_d  = {in_instr[15:0], pend_q};
            pend_d  = in_instr[31:16];
          end
        end
      endcase
    end else if (flush_q && in_ready) begin
      // A fresh flush pulse arriving now stays latched for a later pass.
      flush_d = flush;
      if (state_q == HALF) begin
        word_d  = {16'h0001, pend_q};
        valid_d = 1'b1;
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      pend_q  <= 16'h0000;
      word_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_compressor.sv
// Directed bench for instruction_compressor: vector table for the
// compression rules plus hand sequences for packing, flush and stalls.
module tb_instruction_compressor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cnt_compressed;

  instruction_compressor dut (
    .clk            (clk),
    .rst            (rst),
    .in_instr       (in_instr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_word       (out_word),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .cnt_compressed (cnt_compressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          is_c;
    logic [15:0] parcel;
  } vec_t;

  vec_t        vt[18];
  logic [31:0] q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_cnt = 16'd0;

  always @(negedge clk)
    if (rst && out_valid && out_ready) q.push_back(out_word);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic send(input logic [31:0] i);
    int n = 0;
    @(posedge clk); #1;
    in_instr = i;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready=0, expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic expect_word(input string nm, input logic [31:0] exp);
    int n = 0;
    while (q.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      n_total++;
      $display("FAIL %s: got no word, expected %h", nm, exp);
    end else begin
      chk(nm, q.pop_front(), exp);
    end
  endtask

  task automatic expect_none(input string nm);
    repeat (4) @(negedge clk);
    chk(nm, q.size(), 0);
    q.delete();
  endtask

  initial begin
    vt[0]  = '{32'h00500093, 1'b1, 16'h4095};
    vt[1]  = '{32'hFFF00113, 1'b1, 16'h517D};
    vt[2]  = '{32'h00508093, 1'b1, 16'h0095};
    vt[3]  = '{32'h00008093, 1'b0, 16'h0000};
    vt[4]  = '{32'h02000093, 1'b0, 16'h0000};
    vt[5]  = '{32'hFE000093, 1'b1, 16'h5081};
    vt[6]  = '{32'h004001B3, 1'b1, 16'h8192};
    vt[7]  = '{32'h004181B3, 1'b1, 16'h9192};
    vt[8]  = '{32'h404181B3, 1'b0, 16'h0000};
    vt[9]  = '{32'h00008067, 1'b1, 16'h8082};
    vt[10] = '{32'h000080E7, 1'b0, 16'h0000};
    vt[11] = '{32'h0044A403, 1'b1, 16'h40C0};
    vt[12] = '{32'h0024A403, 1'b0, 16'h0000};
    vt[13] = '{32'h00A5A423, 1'b1, 16'hC588};
    vt[14] = '{32'h07C4A403, 1'b1, 16'h5CE0};
    vt[15] = '{32'h0804A403, 1'b0, 16'h0000};
    vt[16] = '{32'h0044A803, 1'b0, 16'h0000};
    vt[17] = '{32'h123450B7, 1'b0, 16'h0000};

    rst       = 1'b0;
    in_instr  = 32'h0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_cnt", {16'd0, cnt_compressed}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      send(vt[i].instr);
      if (vt[i].is_c) exp_cnt = exp_cnt + 16'd1;
      repeat (3) @(negedge clk);
      do_flush();
      expect_word($sformatf("vec%0d_word", i),
                  vt[i].is_c ? {16'h0001, vt[i].parcel} : vt[i].instr);
      expect_none($sformatf("vec%0d_extra", i));
      chk($sformatf("vec%0d_cnt", i), {16'd0, cnt_compressed},
          {16'd0, exp_cnt});
    end

    send(32'h00500093);
    send(32'hFFF00113);
    exp_cnt = exp_cnt + 16'd2;
    chk("pair_latency", {31'd0, out_valid}, 32'd1);
    expect_word("pair_word", 32'h517D4095);
    expect_none("pair_extra");
    chk("pair_cnt", {16'd0, cnt_compressed}, {16'd0, exp_cnt});

    send(32'h00500093);
    send(32'h123450B7);
    exp_cnt = exp_cnt + 16'd1;
    do_flush();
    expect_word("split_lo", 32'h50B74095);
    expect_word("split_nop", 32'h00011234);
    do_flush();
    expect_none("split_empty_flush");
    chk("split_cnt", {16'd0, cnt_compressed}, {16'd0, exp_cnt});

    send(32'h00500093);
    exp_cnt = exp_cnt + 16'd1;
    @(posedge clk); #1;
    in_instr = 32'h123450B7;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    chk("prio_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    expect_word("prio_input_first", 32'h50B74095);
    expect_word("prio_flush_after", 32'h00011234);
    expect_none("prio_extra");

    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h123450B7);
    in_instr = 32'h00000013;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("stall%0d_word", k), out_word, 32'h123450B7);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_word("stall_drain", 32'h123450B7);
    expect_word("stall_next", 32'h00000013);
    expect_none("stall_extra");
    chk("stall_cnt", {16'd0, cnt_compressed}, {16'd0, exp_cnt});

    send(32'h00500093);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h409500B7);
    @(negedge clk);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_out_word", out_word, 32'h00B74095);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_out_word", out_word, 32'd0);
    chk("rst2_cnt", {16'd0, cnt_compressed}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    do_flush();
    expect_none("rst2_flush_silent");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
